ripple_count_sequencer: RTL and testbench

- Synchronous controller that sequences an 8-bit event counter through arm, run, pause, terminal and acknowledge phases.
- Sits beside the 8-bit counter datapath and gives software/FSM clients a start/stop/pause command interface.
- Provides a programmable terminal count, one-shot or auto-reload modes, a done handshake and a wrap counter.
- All state is clocked on one clock; no derived or rippled clocks are used.

---
 rtl/ripple_count_sequencer_if.sv | 29 ++
 rtl/ripple_count_sequencer.sv | 110 +++++++++++
 tb/tb_ripple_count_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/ripple_count_sequencer_if.sv
// Command/status bundle between an 8-bit counter sequencer and its client.
// The client drives commands through master; the sequencer implements slave.
interface ripple_count_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int WRAPW = 8
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             mode_reload;
    logic [WIDTH-1:0] load_val;
    logic             tick;
    logic             ack;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             paused;
    logic             done;
    logic [WRAPW-1:0] wrap_cnt;

    modport master (
        output start, stop, pause, mode_reload, load_val, tick, ack,
        input  count, busy, paused, done, wrap_cnt
    );

    modport slave (
        input  start, stop, pause, mode_reload, load_val, tick, ack,
        output count, busy, paused, done, wrap_cnt
    );
endinterface

// File: rtl/ripple_count_sequencer.sv
// Arm/run/pause/terminal/acknowledge sequencer for an 8-bit event counter.
// Single clock, synchronous active-high reset, all outputs registered.
module ripple_count_sequencer #(
    parameter int WIDTH = 8,
    parameter int WRAPW = 8
) (
    input logic                     clk,
    input logic                     reset,
    ripple_count_sequencer_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] term;
    logic             mode;
    logic [WIDTH-1:0] count;
    logic [WRAPW-1:0] wrap_cnt;
    logic             busy;
    logic             paused;
    logic             done;

    // Priority ladder: reset > stop > start > pause > tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            term     <= '0;
            mode     <= 1'b0;
            count    <= '0;
            wrap_cnt <= '0;
            busy     <= 1'b0;
            paused   <= 1'b0;
            done     <= 1'b0;
        end else if (bus.stop) begin
            state  <= IDLE;
            busy   <= 1'b0;
            paused <= 1'b0;
            done   <= 1'b0;
        end else if (bus.start) begin
            state    <= RUN;
            term     <= bus.load_val;
            mode     <= bus.mode_reload;
            count    <= '0;
            wrap_cnt <= '0;
            busy     <= 1'b1;
            paused   <= 1'b0;
            done     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    busy   <= 1'b0;
                    paused <= 1'b0;
                    done   <= 1'b0;
                end
                RUN: begin
                    // Clearing here ends the one-cycle reload pulse.
                    done <= 1'b0;
                    if (bus.pause) begin
                        state  <= HOLD;
                        paused <= 1'b1;
                    end else if (bus.tick) begin
                        if (count != term) begin
                            count <= count + 1'b1;
                        end else if (mode) begin
                            count <= '0;
                            done  <= 1'b1;
                            if (wrap_cnt != '1) begin
                                wrap_cnt <= wrap_cnt + 1'b1;
                            end
                        end else begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (!bus.pause) begin
                        state  <= RUN;
                        paused <= 1'b0;
                    end
                end
                DONE: begin
                    if (bus.ack) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy   <= 1'b0;
                    paused <= 1'b0;
                    done   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.count    = count;
    assign bus.busy     = busy;
    assign bus.paused   = paused;
    assign bus.done     = done;
    assign bus.wrap_cnt = wrap_cnt;

endmodule

// File: tb/tb_ripple_count_sequencer.sv
// Randomized plus directed bench for ripple_count_sequencer with a tick-count
// reference model and a queue-based scoreboard.
module tb_ripple_count_sequencer;

    typedef struct {
        int unsigned cyc;
        logic [7:0]  count;
        logic        busy;
        logic        paused;
        logic        done;
        logic [7:0]  wrap_cnt;
    } exp_t;

    typedef enum int {PH_IDLE, PH_RUN, PH_HOLD, PH_DONE} phase_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    ripple_count_sequencer_if #(.WIDTH(8), .WRAPW(8)) bus ();

    ripple_count_sequencer #(.WIDTH(8), .WRAPW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned cycle = 0;

    // Model: the counter is fully described by the number of accepted ticks
    // since the last start, the captured terminal value and the mode.
    phase_t      ph = PH_IDLE;
    int unsigned ticks = 0;
    int unsigned m_term = 0;
    bit          m_reload = 1'b0;

    task automatic check8(input string name, input int unsigned cyc,
                          input logic [7:0] got, input logic [7:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cyc %0d %s: got %0d expected %0d", cyc, name, got, want);
        end
    endtask

    task automatic check1(input string name, input int unsigned cyc,
                          input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL cyc %0d %s: got %b expected %b", cyc, name, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check8("count",    e.cyc, bus.count,    e.count);
                check1("busy",     e.cyc, bus.busy,     e.busy);
                check1("paused",   e.cyc, bus.paused,   e.paused);
                check1("done",     e.cyc, bus.done,     e.done);
                check8("wrap_cnt", e.cyc, bus.wrap_cnt, e.wrap_cnt);
            end
        end
    end

    task automatic step(input bit r, input bit sp, input bit st, input bit pa,
                        input bit mr, input bit tk, input bit ak, input logic [7:0] lv);
        exp_t        e;
        bit          pulse;
        int unsigned period;
        reset           = r;
        bus.stop        = sp;
        bus.start       = st;
        bus.pause       = pa;
        bus.mode_reload = mr;
        bus.tick        = tk;
        bus.ack         = ak;
        bus.load_val    = lv;
        @(posedge clk);
        cycle++;
        pulse = 1'b0;
        if (r) begin
            ph = PH_IDLE; ticks = 0; m_term = 0; m_reload = 1'b0;
        end else if (sp) begin
            ph = PH_IDLE;
        end else if (st) begin
            ph = PH_RUN; ticks = 0; m_term = lv; m_reload = mr;
        end else if (ph == PH_RUN) begin
            if (pa) begin
                ph = PH_HOLD;
            end else if (tk) begin
                ticks++;
                if (m_reload) pulse = (ticks % (m_term + 1) == 0);
                else if (ticks == m_term + 1) ph = PH_DONE;
            end
        end else if (ph == PH_HOLD) begin
            if (!pa) ph = PH_RUN;
        end else if (ph == PH_DONE) begin
            if (ak) ph = PH_IDLE;
        end
        period     = m_term + 1;
        e.cyc      = cycle;
        e.count    = 8'(m_reload ? ticks % period : (ticks < m_term ? ticks : m_term));
        e.wrap_cnt = 8'(m_reload ? ((ticks / period) > 255 ? 255 : ticks / period) : 0);
        e.busy     = (ph == PH_RUN) || (ph == PH_HOLD);
        e.paused   = (ph == PH_HOLD);
        e.done     = (ph == PH_DONE) || pulse;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 8'd0);
    endtask

    task automatic ticks_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(0, 0, 0, 0, 0, 1, 0, 8'd0);
    endtask

    initial begin : stimulus
        bit pause_lvl = 1'b0;
        logic [7:0] lv;
        int unsigned sel;
        @(negedge clk);

        // Reset with random inputs, then tick/ack in IDLE must not move anything.
        for (int i = 0; i < 2; i++)
            step(1, $urandom % 2, $urandom % 2, $urandom % 2, $urandom % 2,
                 $urandom % 2, $urandom % 2, 8'($urandom));
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, 1, 8'd0);

        // One-shot to 5, then ack.
        step(0, 0, 1, 0, 0, 0, 0, 8'd5);
        ticks_n(7);
        step(0, 0, 0, 0, 0, 0, 1, 8'd0);
        idle(2);

        // Reload with terminal 2.
        step(0, 0, 1, 0, 1, 0, 0, 8'd2);
        ticks_n(9);
        step(0, 1, 0, 0, 0, 0, 0, 8'd0);

        // Pause and stop.
        step(0, 0, 1, 0, 0, 0, 0, 8'd10);
        ticks_n(3);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, 1, 0, 8'd0);
        ticks_n(3);
        step(0, 1, 0, 0, 0, 1, 0, 8'd0);
        idle(1);

        // Terminal 0 reload with saturation, then terminal 255 one-shot.
        step(0, 0, 1, 0, 1, 0, 0, 8'd0);
        ticks_n(300);
        step(0, 1, 0, 0, 0, 0, 0, 8'd0);
        step(0, 0, 1, 0, 0, 0, 0, 8'd255);
        ticks_n(258);
        step(0, 0, 0, 0, 0, 0, 1, 8'd0);

        // Collisions.
        step(0, 0, 1, 0, 0, 1, 0, 8'd3);
        step(0, 1, 1, 0, 0, 1, 0, 8'd3);
        step(0, 0, 1, 0, 0, 0, 0, 8'd3);
        ticks_n(5);
        step(0, 0, 1, 0, 1, 1, 1, 8'd4);
        ticks_n(3);
        step(0, 0, 0, 0, 0, 0, 1, 8'd0);
        step(0, 0, 1, 0, 0, 0, 0, 8'd0);
        ticks_n(1);
        step(0, 0, 0, 0, 0, 1, 1, 8'd0);

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom % 10 == 0) pause_lvl = ~pause_lvl;
            sel = $urandom % 8;
            lv = (sel == 0) ? 8'd0 : (sel == 1) ? 8'd255 : 8'($urandom % 12);
            step(($urandom % 300) == 0, ($urandom % 50) == 0, ($urandom % 25) == 0,
                 pause_lvl, $urandom % 2, ($urandom % 4) != 0, ($urandom % 6) == 0, lv);
        end
        idle(2);

        @(posedge clk);
        #3;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
